mastermind_guess_ctrl: RTL and testbench

- Game-control stage directly upstream of the VGA peg-grid renderer.
- Turns single-cycle button pulses into the 6-row x 4-column guess matrix, cursor position, selected colour and guess-row index that the renderer draws.
- Scores each submitted row against a latched secret code as exact and colour-only hits, and sequences win/lose.

---
 rtl/mastermind_guess_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mastermind_guess_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_guess_ctrl.sv
// Mastermind guess controller: builds the peg-grid matrix from button pulses,
// scores each submitted row against the latched secret and sequences win/lose.
//   state   | meaning
//   S_IDLE  | waiting for a start with a legal secret
//   S_INPUT | player edits the active row
//   S_SCORE | one colour per cycle, then a decide cycle
//   S_WIN   | row matched the secret, outputs frozen
//   S_LOSE  | last row failed, secret revealed, outputs frozen
module mastermind_guess_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 4,
    parameter int NCOLORS = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COLS*3-1:0]      secret,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_center,
    output logic [ROWS*COLS*3-1:0] matrix_flat,
    output logic [2:0]             guess_num,
    output logic                   q_Input,
    output logic [1:0]             cursor_index,
    output logic [2:0]             current_color,
    output logic [ROWS*6-1:0]      feedback_flat,
    output logic                   game_win,
    output logic                   game_lose,
    output logic [COLS*3-1:0]      secret_out
);
    localparam int RW = COLS * 3;

    typedef enum logic [2:0] {S_IDLE, S_INPUT, S_SCORE, S_WIN, S_LOSE} state_t;

    state_t                 state_q;
    logic [RW-1:0]          secret_q;
    logic [ROWS*RW-1:0]     matrix_q;
    logic [ROWS*6-1:0]      fb_q;
    logic [2:0]             guess_q;
    logic [1:0]             cursor_q;
    logic [2:0]             color_q;
    logic [2:0]             k_q;
    logic [2:0]             exact_q;
    logic [2:0]             acc_q;
    logic                   q_input_q;
    logic                   win_q;
    logic                   lose_q;
    logic [RW-1:0]          secret_out_q;

    logic [RW-1:0]          row_cur;
    logic                   row_full;
    logic                   secret_ok;
    logic [2:0]             exact_d;
    logic [2:0]             cnt_g;
    logic [2:0]             cnt_s;
    logic [2:0]             min_d;
    logic [2:0]             acc_d;

    function automatic logic [2:0] count_color(input logic [RW-1:0] code, input logic [2:0] color);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++)
            if (code[i*3 +: 3] == color) n = n + 3'd1;
        return n;
    endfunction

    always_comb begin
        row_cur = '0;
        for (int r = 0; r < ROWS; r++)
            if (guess_q == 3'(r)) row_cur = matrix_q[r*RW +: RW];
        row_full  = 1'b1;
        secret_ok = 1'b1;
        exact_d   = '0;
        for (int i = 0; i < COLS; i++) begin
            if (row_cur[i*3 +: 3] == 3'd0) row_full = 1'b0;
            if (row_cur[i*3 +: 3] == secret_q[i*3 +: 3]) exact_d = exact_d + 3'd1;
            if (secret[i*3 +: 3] == 3'd0 || secret[i*3 +: 3] > 3'(NCOLORS)) secret_ok = 1'b0;
        end
        // colour k+1 is scored this cycle; acc restarts at k = 0
        cnt_g = count_color(row_cur, k_q + 3'd1);
        cnt_s = count_color(secret_q, k_q + 3'd1);
        min_d = (cnt_g < cnt_s) ? cnt_g : cnt_s;
        acc_d = ((k_q == 3'd0) ? 3'd0 : acc_q) + min_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            secret_q     <= '0;
            matrix_q     <= '0;
            fb_q         <= '0;
            guess_q      <= '0;
            cursor_q     <= '0;
            color_q      <= 3'd1;
            k_q          <= '0;
            exact_q      <= '0;
            acc_q        <= '0;
            q_input_q    <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            secret_out_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start && secret_ok) begin
                        state_q      <= S_INPUT;
                        secret_q     <= secret;
                        matrix_q     <= '0;
                        fb_q         <= '0;
                        guess_q      <= '0;
                        cursor_q     <= '0;
                        color_q      <= 3'd1;
                        q_input_q    <= 1'b1;
                        win_q        <= 1'b0;
                        lose_q       <= 1'b0;
                        secret_out_q <= '0;
                    end
                end
                S_INPUT: begin
                    if (btn_center) begin
                        if (row_full) begin
                            state_q   <= S_SCORE;
                            q_input_q <= 1'b0;
                            k_q       <= '0;
                        end else begin
                            for (int r = 0; r < ROWS; r++)
                                for (int c = 0; c < COLS; c++)
                                    if (guess_q == 3'(r) && cursor_q == 2'(c))
                                        matrix_q[r*RW + c*3 +: 3] <= color_q;
                            cursor_q <= cursor_q + 2'd1;
                        end
                    end else if (btn_right) begin
                        cursor_q <= cursor_q + 2'd1;
                    end else if (btn_left) begin
                        cursor_q <= cursor_q - 2'd1;
                    end else if (btn_up) begin
                        color_q <= (color_q == 3'(NCOLORS)) ? 3'd1 : color_q + 3'd1;
                    end else if (btn_down) begin
                        color_q <= (color_q == 3'd1) ? 3'(NCOLORS) : color_q - 3'd1;
                    end
                end
                S_SCORE: begin
                    if (k_q == 3'(NCOLORS)) begin
                        if (exact_q == 3'(COLS)) begin
                            state_q <= S_WIN;
                            win_q   <= 1'b1;
                        end else if (guess_q == 3'(ROWS-1)) begin
                            state_q      <= S_LOSE;
                            lose_q       <= 1'b1;
                            secret_out_q <= secret_q;
                        end else begin
                            state_q   <= S_INPUT;
                            guess_q   <= guess_q + 3'd1;
                            cursor_q  <= '0;
                            q_input_q <= 1'b1;
                        end
                    end else begin
                        if (k_q == 3'd0) exact_q <= exact_d;
                        acc_q <= acc_d;
                        if (k_q == 3'(NCOLORS-1))
                            for (int r = 0; r < ROWS; r++)
                                if (guess_q == 3'(r))
                                    fb_q[r*6 +: 6] <= {acc_d - exact_q, exact_q};
                        k_q <= k_q + 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign matrix_flat   = matrix_q;
    assign guess_num     = guess_q;
    assign q_Input       = q_input_q;
    assign cursor_index  = cursor_q;
    assign current_color = color_q;
    assign feedback_flat = fb_q;
    assign game_win      = win_q;
    assign game_lose     = lose_q;
    assign secret_out    = secret_out_q;

endmodule

// File: tb/tb_mastermind_guess_ctrl.sv
// Bench for mastermind_guess_ctrl: game-level model compared every cycle,
// directed game scenarios with literal expectations, then random play.
module tb_mastermind_guess_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] secret = '0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_center = 1'b0;
    logic [71:0] matrix_flat;
    logic [2:0]  guess_num;
    logic        q_Input;
    logic [1:0]  cursor_index;
    logic [2:0]  current_color;
    logic [35:0] feedback_flat;
    logic        game_win, game_lose;
    logic [11:0] secret_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    localparam logic [4:0] B_N = 5'b00000, B_C = 5'b10000, B_R = 5'b01000,
                           B_L = 5'b00100, B_U = 5'b00010, B_D = 5'b00001;

    always #5 clk = ~clk;

    mastermind_guess_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .secret(secret),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_center(btn_center),
        .matrix_flat(matrix_flat), .guess_num(guess_num), .q_Input(q_Input),
        .cursor_index(cursor_index), .current_color(current_color),
        .feedback_flat(feedback_flat), .game_win(game_win), .game_lose(game_lose),
        .secret_out(secret_out)
    );

    // Game-level model: phase of play, grid as integers, timer counting down a scoring pass.
    localparam int PH_IDLE = 0, PH_INPUT = 1, PH_SCORE = 2, PH_WIN = 3, PH_LOSE = 4;
    int          m_ph, m_g, m_cur, m_col, m_tmr;
    int          m_mat[6][4];
    int          m_fe[6], m_fp[6];
    logic [11:0] m_sec;
    int          e, t, cg, cs;

    function automatic bit code_ok(input logic [11:0] c);
        for (int i = 0; i < 4; i++)
            if (c[i*3 +: 3] < 3'd1 || c[i*3 +: 3] > 3'd6) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit row_full(input int r);
        for (int i = 0; i < 4; i++)
            if (m_mat[r][i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_grid();
        for (int r = 0; r < 6; r++) begin
            m_fe[r] = 0;
            m_fp[r] = 0;
            for (int c = 0; c < 4; c++) m_mat[r][c] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_ph = PH_IDLE; m_g = 0; m_cur = 0; m_col = 1; m_tmr = 0; m_sec = '0;
            clear_grid();
        end else begin
            case (m_ph)
                PH_INPUT: begin
                    if (btn_center) begin
                        if (row_full(m_g)) begin
                            m_ph = PH_SCORE;
                            m_tmr = 7;
                        end else begin
                            m_mat[m_g][m_cur] = m_col;
                            m_cur = (m_cur + 1) % 4;
                        end
                    end else if (btn_right) m_cur = (m_cur + 1) % 4;
                    else if (btn_left)  m_cur = (m_cur + 3) % 4;
                    else if (btn_up)    m_col = m_col % 6 + 1;
                    else if (btn_down)  m_col = (m_col + 4) % 6 + 1;
                end
                PH_SCORE: begin
                    m_tmr = m_tmr - 1;
                    if (m_tmr == 1) begin
                        e = 0; t = 0;
                        for (int i = 0; i < 4; i++)
                            if (m_mat[m_g][i] == int'(m_sec[i*3 +: 3])) e++;
                        for (int col = 1; col <= 6; col++) begin
                            cg = 0; cs = 0;
                            for (int i = 0; i < 4; i++) begin
                                if (m_mat[m_g][i] == col) cg++;
                                if (int'(m_sec[i*3 +: 3]) == col) cs++;
                            end
                            t += (cg < cs) ? cg : cs;
                        end
                        m_fe[m_g] = e;
                        m_fp[m_g] = t - e;
                    end else if (m_tmr == 0) begin
                        if (m_fe[m_g] == 4) m_ph = PH_WIN;
                        else if (m_g == 5) m_ph = PH_LOSE;
                        else begin
                            m_g++;
                            m_cur = 0;
                            m_ph = PH_INPUT;
                        end
                    end
                end
                default: begin
                    if (start && code_ok(secret)) begin
                        m_sec = secret; m_g = 0; m_cur = 0; m_col = 1; m_ph = PH_INPUT;
                        clear_grid();
                    end
                end
            endcase
        end
    end

    function automatic logic [71:0] exp_mat();
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++) v[r*12 + c*3 +: 3] = 3'(m_mat[r][c]);
        return v;
    endfunction

    function automatic logic [35:0] exp_fb();
        logic [35:0] v;
        v = '0;
        for (int r = 0; r < 6; r++) v[r*6 +: 6] = {3'(m_fp[r]), 3'(m_fe[r])};
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_matrix", matrix_flat, exp_mat());
            check("m_feedback", 72'(feedback_flat), 72'(exp_fb()));
            check("m_guess_num", 72'(guess_num), 72'(m_g));
            check("m_q_Input", 72'(q_Input), 72'(m_ph == PH_INPUT));
            check("m_cursor", 72'(cursor_index), 72'(m_cur));
            check("m_color", 72'(current_color), 72'(m_col));
            check("m_win", 72'(game_win), 72'(m_ph == PH_WIN));
            check("m_lose", 72'(game_lose), 72'(m_ph == PH_LOSE));
            check("m_secret_out", 72'(secret_out), 72'((m_ph == PH_LOSE) ? m_sec : 12'h000));
        end
    end

    // Drive inputs at a negedge, let one posedge consume them, return at the next negedge.
    task automatic cyc(input logic [4:0] b, input logic st, input logic [11:0] sec);
        {btn_center, btn_right, btn_left, btn_up, btn_down} = b;
        start  = st;
        secret = sec;
        @(negedge clk);
        {btn_center, btn_right, btn_left, btn_up, btn_down} = B_N;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(B_N, 1'b0, secret);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic enter_row(input logic [11:0] code);
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 6 && current_color != code[i*3 +: 3]; n++) cyc(B_U, 1'b0, secret);
            cyc(B_C, 1'b0, secret);
        end
    endtask

    task automatic submit_count_low(output int n);
        cyc(B_C, 1'b0, secret);
        n = 0;
        while (!q_Input && n < 20) begin
            n++;
            cyc(B_N, 1'b0, secret);
        end
    endtask

    initial begin
        int n;
        logic [4:0] b;
        logic [11:0] s;

        @(negedge clk);
        chk_en = 1'b1;
        check("rst_q_Input", 72'(q_Input), 72'(0));
        check("rst_color", 72'(current_color), 72'(1));
        reset = 1'b0;

        cyc(B_N, 1'b1, 12'h000);
        check("bad_start_q_Input", 72'(q_Input), 72'(0));
        cyc(B_C | B_R, 1'b0, 12'h000);
        check("idle_btn_matrix", matrix_flat, 72'(0));
        cyc(B_N, 1'b1, 12'h299);
        check("start_q_Input", 72'(q_Input), 72'(1));
        check("start_guess_num", 72'(guess_num), 72'(0));
        cyc(B_L, 1'b0, secret);
        check("left_wrap", 72'(cursor_index), 72'(3));
        for (int i = 0; i < 6; i++) cyc(B_U, 1'b0, secret);
        check("up_wrap", 72'(current_color), 72'(1));
        cyc(B_C | B_R, 1'b0, secret);
        check("center_prio_cursor", 72'(cursor_index), 72'(0));
        check("center_prio_write", 72'(matrix_flat[11:9]), 72'(1));
        cyc(B_N, 1'b1, 12'h8D1);
        cyc(B_D, 1'b0, secret);
        check("down_wrap", 72'(current_color), 72'(6));

        // Reset in the middle of a scoring pass
        enter_row(12'h299);
        cyc(B_C, 1'b0, secret);
        idle(3);
        do_reset();
        check("rst_mid_matrix", matrix_flat, 72'(0));
        check("rst_mid_q_Input", 72'(q_Input), 72'(0));
        check("rst_mid_color", 72'(current_color), 72'(1));
        cyc(B_C | B_R | B_U, 1'b0, secret);
        check("rst_btn_matrix", matrix_flat, 72'(0));
        check("rst_btn_cursor", 72'(cursor_index), 72'(0));

        // Secret {1,2,3,4}, guess {1,2,4,3}: 2 exact, 2 partial
        cyc(B_N, 1'b1, 12'h8D1);
        enter_row(12'h711);
        check("row0_value", 72'(matrix_flat[11:0]), 72'(12'h711));
        submit_count_low(n);
        check("score_latency", 72'(n), 72'(7));
        check("row0_feedback", 72'(feedback_flat[5:0]), 72'(6'b010_010));
        check("row0_next_guess", 72'(guess_num), 72'(1));

        // Wrong row 1, exact row 2
        enter_row(12'hB6D);
        submit_count_low(n);
        check("row1_latency", 72'(n), 72'(7));
        enter_row(12'h8D1);
        cyc(B_C, 1'b0, secret);
        idle(8);
        check("win_flag", 72'(game_win), 72'(1));
        check("win_guess_num", 72'(guess_num), 72'(2));
        check("win_feedback", 72'(feedback_flat[17:6]), 72'(12'b000_100_000_000));
        cyc(B_C, 1'b0, secret);
        cyc(B_U, 1'b0, secret);
        cyc(B_R, 1'b0, secret);
        check("win_frozen_row", 72'(matrix_flat[35:24]), 72'(12'h8D1));
        check("win_frozen_color", 72'(current_color), 72'(4));
        check("win_frozen_cursor", 72'(cursor_index), 72'(0));

        // Six wrong rows lose the game
        cyc(B_N, 1'b1, 12'h8D1);
        check("restart_matrix", matrix_flat, 72'(0));
        for (int r = 0; r < 6; r++) begin
            enter_row(12'hB6D);
            if (r < 5) begin
                submit_count_low(n);
                check("lose_row_latency", 72'(n), 72'(7));
            end else begin
                cyc(B_C, 1'b0, secret);
                idle(8);
            end
        end
        check("lose_flag", 72'(game_lose), 72'(1));
        check("lose_guess_num", 72'(guess_num), 72'(5));
        check("lose_secret_out", 72'(secret_out), 72'(12'h8D1));
        check("lose_feedback", 72'(feedback_flat), 72'(0));
        cyc(B_N, 1'b1, 12'h299);
        check("after_lose_matrix", matrix_flat, 72'(0));
        check("after_lose_q_Input", 72'(q_Input), 72'(1));
        check("after_lose_secret_out", 72'(secret_out), 72'(0));

        // Random play
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                b = 5'($urandom) & 5'($urandom);
                if ($urandom_range(0, 3) == 0) s = 12'($urandom);
                else s = {3'($urandom_range(1, 6)), 3'($urandom_range(1, 6)),
                          3'($urandom_range(1, 6)), 3'($urandom_range(1, 6))};
                cyc(b, ($urandom_range(0, 15) == 0), s);
            end
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
